// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode/state encodings and result-width helper for the
//               sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_EQ  = 4'd5,
        OP_MUL = 4'd6,
        OP_DIV = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int res_width(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_iter
// Description : Iterative restoring divider, one quotient bit per cycle, with
//               a same-cycle shortcut for division by zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div_iter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int c_CNT_W = $clog2(WIDTH);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic               w_last;
    logic               w_zero_div;

    // Done is raised combinationally on the final step so the caller can
    // register the result on the same edge the last bit is produced.
    always_comb begin
        w_shift     = {r_rem, r_quot[WIDTH-1]};
        w_diff      = w_shift - {1'b0, r_divisor};
        w_qbit      = ~w_diff[WIDTH];
        w_rem_next  = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quot_next = {r_quot[WIDTH-2:0], w_qbit};
        w_last      = r_busy && (r_count == c_CNT_W'(WIDTH - 1));
        w_zero_div  = i_start && (i_divisor == '0);

        o_busy      = r_busy;
        o_done      = w_zero_div || w_last;
        o_div0      = w_zero_div;
        o_quotient  = w_zero_div ? '1 : w_quot_next;
        o_remainder = w_zero_div ? i_dividend : w_rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (i_start && !w_zero_div) begin
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
        end else if (r_busy) begin
            r_rem   <= w_rem_next;
            r_quot  <= w_quot_next;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_core
// Description : Registered ALU with valid/ready input and output handshakes;
//               DIV is delegated to an iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int OP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OP_WIDTH-1:0]  op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   alu_out,
    output logic                 cout,
    output logic                 borrow,
    output logic                 zero,
    output logic                 a_greater,
    output logic                 a_equal,
    output logic                 a_less,
    output logic                 div0,
    output logic                 err
);

    localparam int c_RES_W = res_width(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    state_e             w_accept_state;

    logic [c_RES_W-1:0] r_alu_out;
    logic               r_cout, r_borrow, r_zero, r_gt, r_eq, r_lt, r_div0, r_err;
    logic [2:0]         r_cmp_pend;

    logic               w_accept, w_is_div, w_div_start, w_div_fin;
    logic               w_div_busy, w_div_done, w_div_div0;
    logic [WIDTH-1:0]   w_div_quot, w_div_rem;
    logic [c_RES_W-1:0] w_div_res;
    logic               w_gt, w_eq, w_lt;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [c_RES_W-1:0] w_res;
    logic               w_cout, w_borrow, w_err;

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (arst),
        .i_start     (w_div_start),
        .i_dividend  (a),
        .i_divisor   (b),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_div0      (w_div_div0),
        .o_quotient  (w_div_quot),
        .o_remainder (w_div_rem)
    );

    // Single-cycle datapath and compare flags.
    always_comb begin
        w_gt     = (a > b);
        w_eq     = (a == b);
        w_lt     = (a < b);
        w_sum    = {1'b0, a} + {1'b0, b};
        w_diff   = {1'b0, a} - {1'b0, b};
        w_res    = '0;
        w_cout   = 1'b0;
        w_borrow = 1'b0;
        w_err    = 1'b0;
        case (op)
            OP_ADD: begin
                w_res  = c_RES_W'(w_sum);
                w_cout = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res    = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
                w_borrow = w_diff[WIDTH];
            end
            OP_AND: w_res = c_RES_W'(a & b);
            OP_OR:  w_res = c_RES_W'(a | b);
            OP_XOR: w_res = c_RES_W'(a ^ b);
            OP_EQ:  w_res = c_RES_W'(w_eq);
            OP_MUL: w_res = c_RES_W'(a) * c_RES_W'(b);
            OP_DIV: w_res = '0;
            OP_SHL: w_res = (32'(b) >= 32'(c_RES_W)) ? '0 : (c_RES_W'(a) << b);
            OP_SHR: w_res = (32'(b) >= 32'(WIDTH)) ? '0 : c_RES_W'(a >> b);
            default: w_err = 1'b1;
        endcase
    end

    // Handshake and next state; in_ready deliberately ignores in_valid.
    always_comb begin
        in_ready       = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        out_valid      = (r_state == DONE);
        w_accept       = in_valid && in_ready;
        w_is_div       = (op == OP_DIV);
        w_div_start    = w_accept && w_is_div;
        w_div_fin      = w_div_busy && w_div_done;
        w_div_res      = {w_div_rem, w_div_quot};
        w_accept_state = (w_is_div && !w_div_div0) ? BUSY : DONE;
        w_state_nxt    = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_accept_state;
            BUSY: if (w_div_fin) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = w_accept ? w_accept_state : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result/flag register: updated only when a result is produced.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_alu_out  <= '0;
            r_cout     <= 1'b0;
            r_borrow   <= 1'b0;
            r_zero     <= 1'b0;
            r_gt       <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
            r_div0     <= 1'b0;
            r_err      <= 1'b0;
            r_cmp_pend <= '0;
        end else if (w_accept && !w_is_div) begin
            r_alu_out <= w_res;
            r_cout    <= w_cout;
            r_borrow  <= w_borrow;
            r_zero    <= (w_res == '0);
            {r_gt, r_eq, r_lt} <= {w_gt, w_eq, w_lt};
            r_div0    <= 1'b0;
            r_err     <= w_err;
        end else if (w_div_div0) begin
            r_alu_out <= w_div_res;
            r_cout    <= 1'b0;
            r_borrow  <= 1'b0;
            r_zero    <= (w_div_res == '0);
            {r_gt, r_eq, r_lt} <= {w_gt, w_eq, w_lt};
            r_div0    <= 1'b1;
            r_err     <= 1'b0;
        end else if (w_div_fin) begin
            r_alu_out <= w_div_res;
            r_cout    <= 1'b0;
            r_borrow  <= 1'b0;
            r_zero    <= (w_div_res == '0);
            {r_gt, r_eq, r_lt} <= r_cmp_pend;
            r_div0    <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_div_start) begin
            // Operands may change while the divider runs; keep their compare.
            r_cmp_pend <= {w_gt, w_eq, w_lt};
        end
    end

    assign alu_out   = r_alu_out;
    assign cout      = r_cout;
    assign borrow    = r_borrow;
    assign zero      = r_zero;
    assign a_greater = r_gt;
    assign a_equal   = r_eq;
    assign a_less    = r_lt;
    assign div0      = r_div0;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_core
// Description : Directed and random scoreboard bench for alu_seq_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_core;

    typedef struct packed {
        logic [7:0] res;
        logic       cout, borrow, zero, gt, eq, lt, div0, err;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] a, b, op;
    logic [7:0] alu_out;
    logic       cout, borrow, zero, a_greater, a_equal, a_less, div0, err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(4), .OP_WIDTH(4)) dut (
        .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .cout(cout), .borrow(borrow), .zero(zero),
        .a_greater(a_greater), .a_equal(a_equal), .a_less(a_less),
        .div0(div0), .err(err)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
        exp_t        e;
        logic [31:0] t;
        e    = '0;
        t    = '0;
        e.gt = (x > y);
        e.eq = (x == y);
        e.lt = (x < y);
        case (o)
            4'd0: begin t = 32'(x) + 32'(y); e.res = t[7:0]; e.cout = (t > 32'd15); end
            4'd1: begin t = 32'(x) - 32'(y); e.res = t[7:0]; e.borrow = (x < y); end
            4'd2: e.res = {4'h0, x & y};
            4'd3: e.res = {4'h0, x | y};
            4'd4: e.res = {4'h0, x ^ y};
            4'd5: e.res = {7'd0, x == y};
            4'd6: begin t = 32'(x) * 32'(y); e.res = t[7:0]; end
            4'd7: begin
                if (y == 4'd0) begin
                    e.res  = {x, 4'hF};
                    e.div0 = 1'b1;
                end else begin
                    e.res = {x % y, x / y};
                end
            end
            4'd8: begin t = (y >= 4'd8) ? 32'd0 : (32'(x) << y); e.res = t[7:0]; end
            4'd9: e.res = (y >= 4'd4) ? 8'h00 : {4'h0, x >> y};
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_alu_out"}, 32'(alu_out), 32'(e.res));
            chk({tag, "_flags"},
                32'({cout, borrow, zero, a_greater, a_equal, a_less, div0, err}),
                32'({e.cout, e.borrow, e.zero, e.gt, e.eq, e.lt, e.div0, e.err}));
        end
    endtask

    // Present an op, accept it on the next edge, and queue its expectation.
    task automatic drive(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        chk("in_ready_at_drive", 32'(in_ready), 32'd1);
        sb.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called one cycle after accept; counts cycles until out_valid.
    task automatic wait_out(input string tag, input int exp_lat);
        int cnt = 1;
        while (!out_valid && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        check_result(tag);
        @(posedge clk); #1;
    endtask

    logic [3:0] bb_op[10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd8, 4'd8, 4'd9, 4'd9, 4'd6};
    logic [3:0] bb_a [10] = '{4'd12, 4'd12, 4'd12, 4'd6, 4'd6, 4'd5, 4'd15, 4'd12, 4'd12, 4'd0};
    logic [3:0] bb_b [10] = '{4'd10, 4'd10, 4'd10, 4'd6, 4'd7, 4'd9, 4'd4, 4'd2, 4'd5, 4'd9};

    initial begin
        int         seen;
        logic [3:0] ro, ra, rb;

        arst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_alu_out", 32'(alu_out), 32'd0);
        chk("reset_flags", 32'({cout, borrow, zero, a_greater, a_equal, a_less, div0, err}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        drive(4'd0, 4'd9, 4'd8);   wait_out("add_9_8", 1);
        drive(4'd1, 4'd3, 4'd5);   wait_out("sub_3_5", 1);
        drive(4'd7, 4'd13, 4'd3);  wait_out("div_13_3", 5);
        drive(4'd7, 4'd7, 4'd0);   wait_out("div_7_0", 1);

        // Back-to-back single-cycle ops, one per clock.
        for (int i = 0; i < 10; i++) begin
            op = bb_op[i]; a = bb_a[i]; b = bb_b[i]; in_valid = 1'b1;
            #1;
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk("b2b_out_valid", 32'(out_valid), 32'd1);
                check_result("b2b");
            end
            sb.push_back(model(bb_op[i], bb_a[i], bb_b[i]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("b2b_last_valid", 32'(out_valid), 32'd1);
        check_result("b2b_last");
        @(posedge clk); #1;

        // Backpressure on MUL, then drain and accept ADD in the same cycle.
        out_ready = 1'b0;
        drive(4'd6, 4'd15, 4'd15);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_alu_out_held", 32'(alu_out), 32'hE1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        op = 4'd0; a = 4'd2; b = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp_drain_in_ready", 32'(in_ready), 32'd1);
        check_result("mul_bp");
        sb.push_back(model(4'd0, 4'd2, 4'd3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("add_after_bp_valid", 32'(out_valid), 32'd1);
        check_result("add_after_bp");
        @(posedge clk); #1;

        // Reset during a division: the result must never appear.
        drive(4'd7, 4'd13, 4'd3);
        @(posedge clk); #1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("rst_busy_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy_alu_out", 32'(alu_out), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rst_busy_no_stale", 32'(seen), 32'd0);

        drive(4'hB, 4'd6, 4'd2);   wait_out("illegal_B", 1);
        drive(4'hF, 4'd1, 4'd1);   wait_out("illegal_F", 1);

        // Random mix, including DIV with and without a zero divisor.
        for (int i = 0; i < 24; i++) begin
            ro = 4'($urandom_range(0, 11));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            drive(ro, ra, rb);
            wait_out("rand", (ro == 4'd7 && rb != 4'd0) ? 5 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
